// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: req/gnt/rvalid memory handshake,
// multi-cycle execute, and trap on illegal opcode or memory timeout. Optional perf counters: MC_CTRL_PERF_EN.
module mc_ctrl_fsm #(
    parameter int EXEC_CYCLES = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_gnt_i,
    input  logic       mem_rvalid_i,
    input  logic       trap_clr_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       AdrSrc_o,
    output logic       IRWrite_o,
    output logic       PCUpdate_o,
    output logic       RegWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic       b_en_o,
    output logic       ALUOP_ow_o,
    output logic       trap_o,
    output logic [1:0] trap_cause_o,
`ifdef MC_CTRL_PERF_EN
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_cnt_o,
`endif
    output logic [4:0] state_o
);
    // RV32I major opcodes; OP_NOP is the all-zero encoding and retires nothing.
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_NOP  = 7'b0000000;

    localparam logic [4:0] S_FETCH_REQ = 5'd0,  S_FETCH_WAIT = 5'd1,  S_DECODE = 5'd2;
    localparam logic [4:0] S_MEM_ADR   = 5'd3,  S_RD_REQ     = 5'd4,  S_RD_WAIT = 5'd5;
    localparam logic [4:0] S_WR_REQ    = 5'd6,  S_WR_WAIT    = 5'd7,  S_MEM_WB = 5'd8;
    localparam logic [4:0] S_EXEC_R    = 5'd9,  S_EXEC_I     = 5'd10, S_ALU_WB = 5'd11;
    localparam logic [4:0] S_BRANCH    = 5'd12, S_JAL        = 5'd13, S_JALR1  = 5'd14;
    localparam logic [4:0] S_JALR2     = 5'd15, S_LUI        = 5'd16, S_AUIPC  = 5'd17;
    localparam logic [4:0] S_TRAP      = 5'd18;

    localparam int CW  = (TMO_W < 1) ? 1 : TMO_W;
    localparam int ECW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0]  TMO_LAST  = CW'(MEM_TIMEOUT - 1);
    localparam logic [ECW-1:0] EXEC_LOAD = ECW'(EXEC_CYCLES - 1);

    logic [4:0]     state_q, state_d;
    logic [6:0]     opc_q, opc_d;
    logic [ECW-1:0] exec_q, exec_d;
    logic [CW-1:0]  tmo_q, tmo_d;
    logic [1:0]     cause_q, cause_d;
    logic           in_req, in_wait, tmo_hit;

    always_comb begin
        in_req  = (state_q == S_FETCH_REQ) || (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
        in_wait = (state_q == S_FETCH_WAIT) || (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
        // Completing in the last allowed cycle wins over the timeout.
        tmo_hit = (MEM_TIMEOUT != 0) && (in_req || in_wait) && (tmo_q == TMO_LAST)
                  && !(in_wait && mem_rvalid_i);
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        exec_d  = exec_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH_REQ:  if (mem_gnt_i) state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (mem_rvalid_i) begin
                    opc_d = opcode_i;
                    case (opcode_i)
                        OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR,
                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = S_DECODE;
                        OP_NOP:  state_d = S_FETCH_REQ;
                        default: begin state_d = S_TRAP; cause_d = 2'b01; end
                    endcase
                end
            end
            S_DECODE: begin
                exec_d = EXEC_LOAD;
                case (opc_q)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:     state_d = S_EXEC_R;
                    OP_I:     state_d = S_EXEC_I;
                    OP_BR:    state_d = S_BRANCH;
                    OP_JAL:   state_d = S_JAL;
                    OP_JALR:  state_d = S_JALR1;
                    OP_LUI:   state_d = S_LUI;
                    OP_AUIPC: state_d = S_AUIPC;
                    default:  begin state_d = S_TRAP; cause_d = 2'b01; end
                endcase
            end
            S_MEM_ADR:  state_d = (opc_q == OP_STORE) ? S_WR_REQ : S_RD_REQ;
            S_RD_REQ:   if (mem_gnt_i) state_d = S_RD_WAIT;
            S_WR_REQ:   if (mem_gnt_i) state_d = S_WR_WAIT;
            S_RD_WAIT:  if (mem_rvalid_i) state_d = S_MEM_WB;
            S_WR_WAIT:  if (mem_rvalid_i) state_d = S_FETCH_REQ;
            S_EXEC_R, S_EXEC_I: begin
                if (exec_q == '0) state_d = S_ALU_WB;
                else              exec_d  = exec_q - ECW'(1);
            end
            S_JAL:    state_d = S_ALU_WB;
            S_JALR1:  state_d = S_JALR2;
            S_JALR2:  state_d = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_LUI, S_AUIPC: state_d = S_FETCH_REQ;
            S_TRAP: if (trap_clr_i) begin state_d = S_FETCH_REQ; cause_d = 2'b00; end
            default: state_d = S_FETCH_REQ;
        endcase
        if (tmo_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
        end
        // Fresh budget on entry to a request; REQ and WAIT share one budget.
        tmo_d = tmo_q;
        if ((state_d == S_FETCH_REQ || state_d == S_RD_REQ || state_d == S_WR_REQ)
            && (state_d != state_q))
            tmo_d = '0;
        else if (in_req || in_wait)
            tmo_d = tmo_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH_REQ;
            opc_q   <= '0;
            exec_q  <= '0;
            tmo_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            exec_q  <= exec_d;
            tmo_q   <= tmo_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        mem_req_o = 1'b0; mem_we_o = 1'b0; AdrSrc_o = 1'b0; IRWrite_o = 1'b0;
        PCUpdate_o = 1'b0; RegWrite_o = 1'b0; ResultSrc_o = 2'b00; ALUSrcA_o = 2'b00;
        ALUSrcB_o = 2'b00; b_en_o = 1'b0; ALUOP_ow_o = 1'b0; trap_o = 1'b0;
        case (state_q)
            S_FETCH_REQ:  mem_req_o = 1'b1;
            S_FETCH_WAIT: begin
                ALUSrcB_o = 2'b10; ResultSrc_o = 2'b10; ALUOP_ow_o = 1'b1;
                IRWrite_o = mem_rvalid_i; PCUpdate_o = mem_rvalid_i;
            end
            S_DECODE:  begin ALUSrcA_o = 2'b01; ALUSrcB_o = 2'b01; ALUOP_ow_o = 1'b1; end
            S_MEM_ADR: begin ALUSrcA_o = 2'b10; ALUSrcB_o = 2'b01; end
            S_RD_REQ:  begin mem_req_o = 1'b1; AdrSrc_o = 1'b1; end
            S_WR_REQ:  begin mem_req_o = 1'b1; AdrSrc_o = 1'b1; mem_we_o = 1'b1; end
            S_MEM_WB:  begin ResultSrc_o = 2'b11; RegWrite_o = 1'b1; end
            S_EXEC_R:  ALUSrcA_o = 2'b10;
            S_EXEC_I:  begin ALUSrcA_o = 2'b10; ALUSrcB_o = 2'b01; end
            S_ALU_WB, S_AUIPC: RegWrite_o = 1'b1;
            S_BRANCH:  b_en_o = 1'b1;
            S_JAL, S_JALR2: begin ALUSrcA_o = 2'b01; ALUSrcB_o = 2'b10; PCUpdate_o = 1'b1; end
            S_JALR1:   begin ALUSrcA_o = 2'b10; ALUSrcB_o = 2'b01; end
            S_LUI:     begin ResultSrc_o = 2'b10; RegWrite_o = 1'b1; end
            S_TRAP:    trap_o = 1'b1;
            default: ;
        endcase
        if (rst_i) begin
            mem_req_o = 1'b0; mem_we_o = 1'b0; AdrSrc_o = 1'b0; IRWrite_o = 1'b0;
            PCUpdate_o = 1'b0; RegWrite_o = 1'b0; ResultSrc_o = 2'b00; ALUSrcA_o = 2'b00;
            ALUSrcB_o = 2'b00; b_en_o = 1'b0; ALUOP_ow_o = 1'b0; trap_o = 1'b0;
        end
    end

    assign trap_cause_o = rst_i ? 2'b00 : cause_q;
    assign state_o      = rst_i ? 5'd0  : state_q;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt_q, inst_cnt_q;
    logic        retire;

    assign retire = (state_d == S_FETCH_REQ) &&
                    ((state_q == S_MEM_WB) || (state_q == S_ALU_WB) || (state_q == S_BRANCH) ||
                     (state_q == S_LUI) || (state_q == S_AUIPC) || (state_q == S_WR_WAIT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q  <= '0;
            inst_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (retire) inst_cnt_q <= inst_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt_o   = rst_i ? 32'd0 : cyc_cnt_q;
    assign instret_cnt_o = rst_i ? 32'd0 : inst_cnt_q;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-instruction expectations derived from the
// state/latency rules are queued by the stimulus and checked by an independent monitor.
module tb_mc_ctrl_fsm;
    localparam int T = 16;
    localparam int N = 4;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    localparam logic [4:0] S_FR = 0, S_FW = 1, S_DEC = 2, S_MADR = 3, S_RDREQ = 4, S_RDW = 5;
    localparam logic [4:0] S_WRREQ = 6, S_WRW = 7, S_MWB = 8, S_EXR = 9, S_EXI = 10, S_AWB = 11;
    localparam logic [4:0] S_BR = 12, S_JAL = 13, S_JALR1 = 14, S_JALR2 = 15, S_LUI = 16;
    localparam logic [4:0] S_AUIPC = 17, S_TRAP = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i = 1'b1, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, trap_clr_i = 1'b0;
    logic [6:0] opcode_i = 7'd0;
    logic mem_req_o, mem_we_o, AdrSrc_o, IRWrite_o, PCUpdate_o, RegWrite_o, b_en_o, ALUOP_ow_o, trap_o;
    logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o, trap_cause_o;
    logic [4:0] state_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_o, instret_cnt_o;
`endif

    mc_ctrl_fsm #(.EXEC_CYCLES(N), .MEM_TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .trap_clr_i(trap_clr_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .AdrSrc_o(AdrSrc_o), .IRWrite_o(IRWrite_o), .PCUpdate_o(PCUpdate_o),
        .RegWrite_o(RegWrite_o), .ResultSrc_o(ResultSrc_o), .ALUSrcA_o(ALUSrcA_o),
        .ALUSrcB_o(ALUSrcB_o), .b_en_o(b_en_o), .ALUOP_ow_o(ALUOP_ow_o), .trap_o(trap_o),
        .trap_cause_o(trap_cause_o),
`ifdef MC_CTRL_PERF_EN
        .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o),
`endif
        .state_o(state_o)
    );

    typedef struct {
        int cyc, rw, rs, pcu, irw, we, req, ben, cause;
        bit trap, retire;
        logic [31:0] vis;
    } exp_t;

    exp_t sb[$];
    int checks = 0, passes = 0;
    logic [6:0] legal_ops [9];

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    endtask

    task automatic bound_fail(string name);
        checks++;
        $display("FAIL %s actual=timeout expected=event (t=%0t)", name, $time);
    endtask

    function automatic bit is_legal(logic [6:0] op);
        for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Expected observable footprint of one instruction, from fetch to the next FETCH_REQ or TRAP.
    function automatic exp_t model(logic [6:0] op, int g, int r, int g2, int r2);
        exp_t e;
        int fl, fl2;
        bit ld;
        e = '{cyc: 0, rw: 0, rs: 0, pcu: 0, irw: 0, we: 0, req: 0, ben: 0, cause: 0,
              trap: 0, retire: 0, vis: 32'd1 << S_FR};
        fl = g + r + 2;
        if (fl > T) begin
            e.cyc = T; e.req = min2(g + 1, T); e.trap = 1; e.cause = 2;
            if (g <= T - 2) e.vis |= 32'd1 << S_FW;
            return e;
        end
        e.vis |= 32'd1 << S_FW; e.cyc = fl; e.irw = 1; e.pcu = 1; e.req = g + 1;
        if (op == 7'd0) return e;
        if (!is_legal(op)) begin e.trap = 1; e.cause = 1; return e; end
        e.vis |= 32'd1 << S_DEC; e.cyc += 1;
        case (op)
            OP_R, OP_I: begin
                e.vis |= 32'd1 << ((op == OP_R) ? S_EXR : S_EXI) | 32'd1 << S_AWB;
                e.cyc += N + 1; e.rw = 1; e.retire = 1;
            end
            OP_BR: begin e.vis |= 32'd1 << S_BR; e.cyc += 1; e.ben = 1; e.retire = 1; end
            OP_JAL: begin
                e.vis |= 32'd1 << S_JAL | 32'd1 << S_AWB; e.cyc += 2; e.pcu = 2; e.rw = 1; e.retire = 1;
            end
            OP_JALR: begin
                e.vis |= 32'd1 << S_JALR1 | 32'd1 << S_JALR2 | 32'd1 << S_AWB;
                e.cyc += 3; e.pcu = 2; e.rw = 1; e.retire = 1;
            end
            OP_LUI:   begin e.vis |= 32'd1 << S_LUI; e.cyc += 1; e.rw = 1; e.rs = 2; e.retire = 1; end
            OP_AUIPC: begin e.vis |= 32'd1 << S_AUIPC; e.cyc += 1; e.rw = 1; e.retire = 1; end
            default: begin
                ld = (op == OP_LOAD);
                e.vis |= 32'd1 << S_MADR | 32'd1 << (ld ? S_RDREQ : S_WRREQ);
                e.cyc += 1;
                fl2 = g2 + r2 + 2;
                if (fl2 > T) begin
                    e.cyc += T; e.req += min2(g2 + 1, T); e.trap = 1; e.cause = 2;
                    if (!ld) e.we = min2(g2 + 1, T);
                    if (g2 <= T - 2) e.vis |= 32'd1 << (ld ? S_RDW : S_WRW);
                end else begin
                    e.cyc += fl2; e.req += g2 + 1; e.retire = 1;
                    e.vis |= 32'd1 << (ld ? S_RDW : S_WRW);
                    if (ld) begin e.vis |= 32'd1 << S_MWB; e.cyc += 1; e.rw = 1; e.rs = 3; end
                    else e.we = g2 + 1;
                end
            end
        endcase
        return e;
    endfunction

    // {ResultSrc, ALUSrcA, ALUSrcB, ALUOP_ow, AdrSrc} required in each state.
    function automatic logic [8:0] exp_mux(logic [4:0] s);
        case (s)
            S_FW:            return 9'b10_00_10_1_0;
            S_DEC:           return 9'b00_01_01_1_0;
            S_MADR, S_JALR1: return 9'b00_10_01_0_0;
            S_RDREQ, S_WRREQ: return 9'b00_00_00_0_1;
            S_MWB:           return 9'b11_00_00_0_0;
            S_EXR:           return 9'b00_10_00_0_0;
            S_EXI:           return 9'b00_10_01_0_0;
            S_JAL, S_JALR2:  return 9'b00_01_10_0_0;
            S_LUI:           return 9'b10_00_00_0_0;
            default:         return 9'b0;
        endcase
    endfunction

    // Monitor
    bit open = 0, after_rst = 0;
    logic [4:0] prev = 5'd31;
    int a_cyc, a_rw, a_rs, a_pcu, a_irw, a_we, a_req, a_ben;
    logic [31:0] a_vis, inst_start;

    task automatic close_rec(bit trapped);
        exp_t e;
        chk("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("cycles", a_cyc, e.cyc);     chk("regwrite", a_rw, e.rw);
        chk("resultsrc", a_rs, e.rs);    chk("pcupdate", a_pcu, e.pcu);
        chk("irwrite", a_irw, e.irw);    chk("mem_we", a_we, e.we);
        chk("mem_req", a_req, e.req);    chk("b_en", a_ben, e.ben);
        chk("visited", int'(a_vis), int'(e.vis)); chk("trapped", int'(trapped), int'(e.trap));
        if (trapped) begin
            chk("trap_cause", trap_cause_o, e.cause);
            chk("trap_req", mem_req_o, 0);
        end
`ifdef MC_CTRL_PERF_EN
        chk("instret", int'(instret_cnt_o - inst_start), int'(e.retire));
`endif
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            chk("rst_outputs_zero", int'({mem_req_o, mem_we_o, AdrSrc_o, IRWrite_o, PCUpdate_o,
                RegWrite_o, ResultSrc_o, ALUSrcA_o, ALUSrcB_o, b_en_o, ALUOP_ow_o, trap_o,
                trap_cause_o, state_o}), 0);
            open = 0; prev = 5'd31; after_rst = 1;
        end else begin
            if (after_rst) begin
                chk("post_rst_state", state_o, S_FR);
                after_rst = 0;
            end
            chk("mux", {ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOP_ow_o, AdrSrc_o}, exp_mux(state_o));
            chk("trap_o", trap_o, int'(state_o == S_TRAP));
            if (state_o == S_TRAP && prev != S_TRAP) begin
                if (open) close_rec(1'b1);
                open = 0;
            end else if (state_o == S_FR && prev != S_FR) begin
                if (open) close_rec(1'b0);
                chk("fetch_cause_clear", trap_cause_o, 0);
                open = 1; a_cyc = 0; a_rw = 0; a_rs = 0; a_pcu = 0; a_irw = 0;
                a_we = 0; a_req = 0; a_ben = 0; a_vis = 0;
`ifdef MC_CTRL_PERF_EN
                inst_start = instret_cnt_o;
`else
                inst_start = 0;
`endif
            end
            if (open) begin
                a_cyc++; a_rw += RegWrite_o; a_pcu += PCUpdate_o; a_irw += IRWrite_o;
                a_we += mem_we_o; a_req += mem_req_o; a_ben += b_en_o;
                if (RegWrite_o) a_rs = ResultSrc_o;
                a_vis |= 32'd1 << state_o;
            end
            prev = state_o;
        end
    end

    // Stimulus
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mem_txn(int g, int r, bit both, logic [6:0] op);
        repeat (g) step();
        mem_gnt_i = 1'b1; mem_rvalid_i = both;
        step();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        repeat (r) step();
        mem_rvalid_i = 1'b1; opcode_i = op;
        step();
        mem_rvalid_i = 1'b0; opcode_i = 7'($urandom);
    endtask

    task automatic run_instr(logic [6:0] op, int g, int r, bit both, int g2, int r2, bit both2);
        int k;
        sb.push_back(model(op, g, r, g2, r2));
        mem_txn(g, r, both, op);
        if (g + r + 2 <= T && (op == OP_LOAD || op == OP_STORE)) begin
            k = 0;
            while (!mem_req_o && k < 50) begin step(); k++; end
            if (k >= 50) bound_fail("wait_data_req");
            mem_txn(g2, r2, both2, 7'($urandom));
        end
        k = 0;
        while (!(state_o == S_FR || state_o == S_TRAP) && k < 100) begin step(); k++; end
        if (k >= 100) bound_fail("wait_instr_end");
        if (state_o == S_TRAP) begin
            repeat ($urandom_range(0, 3)) step();
            trap_clr_i = 1'b1;
            step();
            trap_clr_i = 1'b0;
        end
    endtask

    function automatic int rand_lat();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [6:0] op;
        int k, sel;
        legal_ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        rst_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;

        run_instr(OP_R, 1, 0, 0, 0, 0, 0);
        run_instr(OP_LOAD, 0, 0, 0, 2, 2, 0);
        run_instr(OP_STORE, 0, 0, 0, 20, 0, 0);
        run_instr(7'h7f, 0, 1, 0, 0, 0, 0);
        run_instr(7'h00, 0, 0, 0, 0, 0, 0);
        run_instr(OP_I, 2, 1, 1, 0, 0, 0);
        run_instr(OP_JALR, 0, 0, 0, 0, 0, 0);
        run_instr(OP_LOAD, 0, 0, 0, 5, 9, 1);
        run_instr(OP_STORE, 0, 0, 0, 3, 11, 0);

        // Reset in the middle of a multi-cycle execute abandons the instruction.
        mem_txn(0, 0, 0, OP_I);
        k = 0;
        while (state_o != S_EXI && k < 20) begin step(); k++; end
        if (k >= 20) bound_fail("wait_exec_i");
        step();
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;

        for (int n = 0; n < 160; n++) begin
            sel = $urandom_range(0, 11);
            if (sel < 9) op = legal_ops[sel];
            else if (sel == 9) op = 7'd0;
            else begin
                op = 7'($urandom);
                while (is_legal(op) || op == 7'd0) op = 7'($urandom);
            end
            run_instr(op, rand_lat(), rand_lat(), 1'($urandom), rand_lat(), rand_lat(), 1'($urandom));
        end

        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
